// File: rtl/mdio_pkg.sv
// mdio_pkg: Clause-22 frame constants, field widths, command struct and FSM state codes shared by mdio_master.
// The TX frame helper yields the 32 post-preamble bits (ST, OP, PHYAD, REGAD, TA, DATA) msb-first.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int MDIO_PHYAD_W = 5;
  localparam int MDIO_REGAD_W = 5;
  localparam int MDIO_DATA_W  = 16;
  localparam int MDIO_HDR_W   = 14;
  localparam int MDIO_TA_W    = 2;
  localparam int MDIO_TX_W    = MDIO_HDR_W + MDIO_TA_W + MDIO_DATA_W;

  typedef logic [2:0] mdio_state_t;
  localparam mdio_state_t ST_IDLE     = 3'd0;
  localparam mdio_state_t ST_PREAMBLE = 3'd1;
  localparam mdio_state_t ST_HDR      = 3'd2;
  localparam mdio_state_t ST_TA       = 3'd3;
  localparam mdio_state_t ST_DATA     = 3'd4;

  typedef struct packed {
    logic                    write;
    logic [MDIO_PHYAD_W-1:0] phy_addr;
    logic [MDIO_REGAD_W-1:0] reg_addr;
    logic [MDIO_DATA_W-1:0]  wdata;
  } mdio_cmd_t;

  // Read frames carry all-ones past the header so the released bits idle high.
  function automatic logic [MDIO_TX_W-1:0] mdio_tx_frame(input mdio_cmd_t cmd);
    if (cmd.write)
      return {MDIO_ST, MDIO_OP_WR, cmd.phy_addr, cmd.reg_addr, MDIO_TA_WR, cmd.wdata};
    else
      return {MDIO_ST, MDIO_OP_RD, cmd.phy_addr, cmd.reg_addr, 2'b11, 16'hFFFF};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC divider, CLK_DIV cycles low then CLK_DIV high per bit; first low phase begins the cycle after i_en rises.
// No backpressure; counter and MDC clear synchronously whenever i_en is low. o_rise marks the first high cycle, o_fall the last.
module mdio_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_mdc,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (cnt == LAST) cnt_nxt = '0;
  end

  // MDC is registered from the same next-count as cnt so the pad sees a clean edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_en) begin
      cnt   <= '0;
      o_mdc <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      o_mdc <= (cnt_nxt >= HALF);
    end
  end

  assign o_rise = i_en && (cnt == HALF);
  assign o_fall = i_en && (cnt == LAST);

endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master; o_done at T+1+2*CLK_DIV*(PREAMBLE_LEN+32) after accept (32 bits only with suppression).
// o_cmd_ready low while a frame is in flight, valid while busy is dropped. Option MDIO_PREAMBLE_SUPPRESS_EN adds i_preamble_suppress.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        i_preamble_suppress,
`endif
  output logic [15:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_done,
  output logic        o_ta_err,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  localparam logic [6:0] PRE_LAST  = 7'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [6:0] HDR_LAST  = 7'(MDIO_HDR_W - 1);
  localparam logic [6:0] TA_LAST   = 7'(MDIO_TA_W - 1);
  localparam logic [6:0] DATA_LAST = 7'(MDIO_DATA_W - 1);

  mdio_state_t            state;
  logic [6:0]             bit_cnt;
  logic [MDIO_TX_W-1:0]   tx_sr;
  logic [MDIO_DATA_W-1:0] rx_sr;
  logic                   is_write;
  logic                   ta_bad;

  logic                   busy;
  logic                   accept;
  logic                   skip_pre;
  logic                   last_bit;
  logic                   mdc_rise;
  logic                   mdc_fall;
  mdio_cmd_t              cmd_in;
  logic [MDIO_TX_W-1:0]   frame_in;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign skip_pre = i_preamble_suppress;
`else
  assign skip_pre = 1'b0;
`endif

  assign busy        = (state != ST_IDLE);
  assign o_cmd_ready = !busy;
  assign accept      = i_cmd_valid && !busy;

  assign cmd_in   = '{write: i_cmd_write, phy_addr: i_phy_addr, reg_addr: i_reg_addr, wdata: i_wdata};
  assign frame_in = mdio_tx_frame(cmd_in);

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (busy),
    .o_mdc     (o_mdc),
    .o_rise    (mdc_rise),
    .o_fall    (mdc_fall)
  );

  always_comb begin
    last_bit = 1'b0;
    case (state)
      ST_PREAMBLE: last_bit = (bit_cnt == PRE_LAST);
      ST_HDR:      last_bit = (bit_cnt == HDR_LAST);
      ST_TA:       last_bit = (bit_cnt == TA_LAST);
      ST_DATA:     last_bit = (bit_cnt == DATA_LAST);
      default:     last_bit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      is_write      <= 1'b0;
      ta_bad        <= 1'b0;
      o_mdio_out    <= 1'b1;
      o_mdio_oe     <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_done        <= 1'b0;
      o_ta_err      <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      o_rdata_valid <= 1'b0;

      // The first bit is presented in the first low phase, i.e. the cycle after accept.
      if (accept) begin
        is_write  <= i_cmd_write;
        bit_cnt   <= '0;
        o_mdio_oe <= 1'b1;
        if ((PREAMBLE_LEN > 0) && !skip_pre) begin
          state      <= ST_PREAMBLE;
          o_mdio_out <= 1'b1;
          tx_sr      <= frame_in;
        end else begin
          state      <= ST_HDR;
          o_mdio_out <= frame_in[MDIO_TX_W-1];
          tx_sr      <= {frame_in[MDIO_TX_W-2:0], 1'b1};
        end
      end

      if (busy && mdc_rise) begin
        if (state == ST_TA && last_bit) ta_bad <= i_mdio_in;
        if (state == ST_DATA) rx_sr <= {rx_sr[MDIO_DATA_W-2:0], i_mdio_in};
      end

      // Next bit's drive value is launched on the MDC falling transition.
      if (busy && mdc_fall) begin
        if (state == ST_DATA && last_bit) begin
          state      <= ST_IDLE;
          bit_cnt    <= '0;
          o_mdio_out <= 1'b1;
          o_mdio_oe  <= 1'b0;
          o_done     <= 1'b1;
          if (!is_write) begin
            o_rdata       <= rx_sr;
            o_rdata_valid <= 1'b1;
            o_ta_err      <= ta_bad;
          end
        end else begin
          bit_cnt   <= last_bit ? 7'd0 : bit_cnt + 7'd1;
          o_mdio_oe <= is_write || (state == ST_PREAMBLE) || (state == ST_HDR && !last_bit);
          if (state == ST_PREAMBLE && !last_bit) begin
            o_mdio_out <= 1'b1;
          end else begin
            o_mdio_out <= tx_sr[MDIO_TX_W-1];
            tx_sr      <= {tx_sr[MDIO_TX_W-2:0], 1'b1};
          end
          if (last_bit) begin
            case (state)
              ST_PREAMBLE: state <= ST_HDR;
              ST_HDR:      state <= ST_TA;
              ST_TA:       state <= ST_DATA;
              default:     state <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: table-driven and randomized checks of mdio_master against a cycle-position reference model
// (CLK_DIV=2, PREAMBLE_LEN=32), with a behavioural PHY answering reads.
module tb_mdio_master;

  localparam int CD   = 2;
  localparam int PL   = 32;
  localparam int BITP = 2 * CD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_write;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wdata;
  logic        mdio_in;
  logic        pre_sup;
  logic        cmd_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        ta_err;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_rd;
  logic        m_err;
  logic        r_wr, r_pres, r_ta;
  logic [4:0]  r_phy, r_rg;
  logic [15:0] r_d;
  int          r_gap;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(CD), .PREAMBLE_LEN(PL)) dut (
    .i_clk               (clk),
    .i_reset_n           (reset_n),
    .i_cmd_valid         (cmd_valid),
    .o_cmd_ready         (cmd_ready),
    .i_cmd_write         (cmd_write),
    .i_phy_addr          (phy_addr),
    .i_reg_addr          (reg_addr),
    .i_wdata             (wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .i_preamble_suppress (pre_sup),
`endif
    .o_rdata             (rdata),
    .o_rdata_valid       (rdata_valid),
    .o_done              (done),
    .o_ta_err            (ta_err),
    .o_mdc               (mdc),
    .o_mdio_out          (mdio_out),
    .o_mdio_oe           (mdio_oe),
    .i_mdio_in           (mdio_in)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] d;
    logic        present;
    logic        ta;
    int          gap;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_frame(input logic wr, input logic [4:0] phy,
                                              input logic [4:0] rg, input logic [15:0] d);
    logic [1:0] op;
    op = wr ? 2'b01 : 2'b10;
    return {2'b01, op, phy, rg, 2'b10, d};
  endfunction

  // PHY: releases the first TA bit (pull-up), drives the second, then data msb-first.
  function automatic logic phy_bit(input int b, input int n_pre, input logic present,
                                   input logic ta, input logic [15:0] d);
    int j;
    j = b - n_pre;
    if (!present || j < 15 || j >= 32) return 1'b1;
    if (j == 15) return ta;
    return d[31 - j];
  endfunction

  task automatic model_update(input logic wr, input logic present, input logic ta, input logic [15:0] d);
    if (!wr) begin
      m_rd  = present ? d : 16'hFFFF;
      m_err = present ? ta : 1'b1;
    end
  endtask

  task automatic idle(input int n, input string tag);
    int bad;
    bad = 0;
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done !== 1'b0 || rdata_valid !== 1'b0 || mdc !== 1'b0 || cmd_ready !== 1'b1 ||
          mdio_oe !== 1'b0 || mdio_out !== 1'b1) bad++;
    end
    chk({tag, "_idle_quiet"}, bad, 0);
  endtask

  // Issues one command in the current cycle and follows it to its done cycle (returns in that cycle).
  task automatic run_cmd(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] d, input logic present, input logic ta,
                         input logic sup, input logic hold,
                         input logic [15:0] exp_rdata, input logic exp_err, input string tag);
    int n_pre, n_bits, k_done, k, b, ph, done_k;
    int bad_mdc, bad_out, bad_oe, bad_busy;
    logic [31:0] fr;
    logic exp_m, exp_o, exp_e;
    n_pre    = sup ? 0 : PL;
    n_bits   = n_pre + 32;
    k_done   = 1 + BITP * n_bits;
    fr       = model_frame(wr, phy, rg, d);
    done_k   = 0;
    bad_mdc  = 0;
    bad_out  = 0;
    bad_oe   = 0;
    bad_busy = 0;
    chk({tag, "_accept_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    phy_addr  = phy;
    reg_addr  = rg;
    wdata     = d;
    pre_sup   = sup;
    tick();
    k = 1;
    while (k <= k_done + 8) begin
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      b  = (k - 1) / BITP;
      ph = (k - 1) % BITP;
      if (b < n_bits) begin
        exp_m = (ph >= CD);
        exp_o = (b < n_pre) ? 1'b1 : fr[31 - (b - n_pre)];
        exp_e = (b < n_pre + 14) ? 1'b1 : wr;
        if (mdc !== exp_m) bad_mdc++;
        if (mdio_oe !== exp_e) bad_oe++;
        if (exp_e && mdio_out !== exp_o) bad_out++;
      end
      if (cmd_ready !== 1'b0 || rdata_valid !== 1'b0) bad_busy++;
      mdio_in = wr ? 1'($urandom_range(0, 1)) : phy_bit(b, n_pre, present, ta, d);
      if (!hold) begin
        cmd_valid = (k < k_done - 4) && ($urandom_range(0, 7) == 0);
        cmd_write = 1'($urandom_range(0, 1));
        phy_addr  = 5'($urandom_range(0, 31));
        reg_addr  = 5'($urandom_range(0, 31));
        wdata     = 16'($urandom_range(0, 65535));
        pre_sup   = 1'($urandom_range(0, 1));
      end
      tick();
      k++;
    end
    chk({tag, "_done_cycle"}, done_k, k_done);
    chk({tag, "_mdc_shape"}, bad_mdc, 0);
    chk({tag, "_mdio_bits"}, bad_out, 0);
    chk({tag, "_mdio_oe"}, bad_oe, 0);
    chk({tag, "_busy_flags"}, bad_busy, 0);
    chk({tag, "_end_mdc"}, mdc, 0);
    chk({tag, "_end_oe"}, mdio_oe, 0);
    chk({tag, "_end_out"}, mdio_out, 1);
    chk({tag, "_end_ready"}, cmd_ready, 1);
    chk({tag, "_rvalid"}, rdata_valid, !wr);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_ta_err"}, ta_err, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b0, 1, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'd3, 5'd2, 16'h0141, 1'b1, 1'b0, 0, 16'h0141, 1'b0};
    tbl[2] = '{1'b0, 5'd5, 5'd7, 16'h0000, 1'b0, 1'b0, 3, 16'hFFFF, 1'b1};
    tbl[3] = '{1'b1, 5'd31, 5'd31, 16'hA5A5, 1'b0, 1'b0, 0, 16'hFFFF, 1'b1};
    tbl[4] = '{1'b0, 5'd0, 5'd1, 16'h1234, 1'b1, 1'b1, 2, 16'h1234, 1'b1};
    tbl[5] = '{1'b0, 5'd2, 5'd3, 16'hBEEF, 1'b1, 1'b0, 1, 16'hBEEF, 1'b0};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    phy_addr  = '0;
    reg_addr  = '0;
    wdata     = '0;
    mdio_in   = 1'b1;
    pre_sup   = 1'b0;
    m_rd      = 16'h0000;
    m_err     = 1'b0;
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_mdc", mdc, 0);
    chk("rst_oe", mdio_oe, 0);
    chk("rst_out", mdio_out, 1);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ta_err", ta_err, 0);
    reset_n = 1'b1;
    idle(3, "boot");

    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i].wr, tbl[i].phy, tbl[i].rg, tbl[i].d, tbl[i].present, tbl[i].ta,
              1'b0, 1'b0, tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("tbl%0d", i));
      model_update(tbl[i].wr, tbl[i].present, tbl[i].ta, tbl[i].d);
      if (tbl[i].gap > 0) idle(tbl[i].gap, $sformatf("tbl%0d", i));
    end

    // Valid held high through two frames: the second is taken in the first's done cycle.
    run_cmd(1'b1, 5'd4, 5'd9, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1, m_rd, m_err, "hold_a");
    model_update(1'b0, 1'b1, 1'b0, 16'hC3A5);
    run_cmd(1'b0, 5'd6, 5'd17, 16'hC3A5, 1'b1, 1'b0, 1'b0, 1'b1, m_rd, m_err, "hold_b");
    idle(2, "hold");

    // Synchronous reset mid-DATA aborts the frame with no done pulse.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    phy_addr  = 5'd9;
    reg_addr  = 5'd4;
    wdata     = 16'h5A5A;
    tick();
    cmd_valid = 1'b0;
    repeat (BITP * (PL + 20)) tick();
    chk("mid_busy", cmd_ready, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_mdc", mdc, 0);
    chk("mid_rst_oe", mdio_oe, 0);
    chk("mid_rst_out", mdio_out, 1);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdata", rdata, 16'h0000);
    m_rd  = 16'h0000;
    m_err = 1'b0;
    idle(40, "mid_rst");
    model_update(1'b0, 1'b1, 1'b0, 16'h7E81);
    run_cmd(1'b0, 5'd9, 5'd4, 16'h7E81, 1'b1, 1'b0, 1'b0, 1'b0, m_rd, m_err, "post_rst");
    idle(2, "post_rst");

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    run_cmd(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b0, 1'b1, 1'b0, m_rd, m_err, "sup_wr");
    idle(1, "sup_wr");
    model_update(1'b0, 1'b1, 1'b0, 16'h0141);
    run_cmd(1'b0, 5'd3, 5'd2, 16'h0141, 1'b1, 1'b0, 1'b1, 1'b0, m_rd, m_err, "sup_rd");
    idle(1, "sup_rd");
`endif

    for (int i = 0; i < 8; i++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_phy  = 5'($urandom_range(0, 31));
      r_rg   = 5'($urandom_range(0, 31));
      r_d    = 16'($urandom_range(0, 65535));
      r_pres = ($urandom_range(0, 3) != 0);
      r_ta   = ($urandom_range(0, 3) == 0);
      r_gap  = int'($urandom_range(0, 2));
      model_update(r_wr, r_pres, r_ta, r_d);
      run_cmd(r_wr, r_phy, r_rg, r_d, r_pres, r_ta, 1'b0, 1'b0, m_rd, m_err, $sformatf("rand%0d", i));
      if (r_gap > 0) idle(r_gap, $sformatf("rand%0d", i));
    end
    idle(2, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised Clause-22 MDIO management master; successor to the fixed-frame MDIO tester.
- Generates MDC from i_clk with a programmable divider and a programmable preamble length.
- Builds the full ST/OP/PHYAD/REGAD/TA/DATA frame from discrete fields, checks read turnaround, and returns read data over a valid/ready command handshake.
- Sits between the management CPU/config FSM and the PHY pad; the tri-state buffer lives at top level.

Parameters:
- CLK_DIV, 10: i_clk cycles per MDC half-period; legal values ≥2.
- PREAMBLE_LEN, 32: number of preamble '1' bits; legal range 0..64.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  block idle, command accepted when valid&ready
- i_cmd_write  in  1  1=write (OP 01), 0=read (OP 10)
- i_phy_addr  in  5  PHYAD
- i_reg_addr  in  5  REGAD
- i_wdata  in  16  write data
- o_rdata  out  16  last read data
- o_rdata_valid  out  1  one-cycle pulse, read complete
- o_done  out  1  one-cycle pulse, any transaction complete
- o_ta_err  out  1  last read saw TA bit 2 ≠ 0; held until next read completes
- o_mdc  out  1  management clock
- o_mdio_out  out  1  MDIO drive value
- o_mdio_oe  out  1  MDIO output enable
- i_mdio_in  in  1  MDIO pad input

Behaviour:
- Reset (i_reset_n=0 at a rising edge):
  - State returns to IDLE, divider cleared.
  - o_cmd_ready=1, o_mdc=0, o_mdio_oe=0, o_mdio_out=1.
  - o_rdata=0, o_rdata_valid=0, o_done=0, o_ta_err=0.
  - Applies mid-frame: the frame is aborted and no done pulse is issued.
- Accept in cycle T when i_cmd_valid & o_cmd_ready:
  - Fields are captured; later input changes are ignored.
  - o_cmd_ready=0 from T+1.
  - i_cmd_valid while busy is ignored; no queueing.
- MDC:
  - Held 0 in IDLE.
  - While busy: low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit. Bit period = 2*CLK_DIV cycles.
  - The first low phase starts at T+1.
- Drive/sample timing:
  - Outputs (o_mdio_out, o_mdio_oe) update at the start of each low phase, i.e. on the MDC falling transition and at T+1.
  - i_mdio_in is sampled in the cycle MDC goes high.
- States: IDLE -> PREAMBLE (PREAMBLE_LEN bits of 1, oe=1; skipped if 0) -> HDR (14 bits: 01, OP, PHYAD msb-first, REGAD msb-first, oe=1) -> TA (2 bits) -> DATA (16 bits) -> IDLE.
- Write frame: TA driven as 1,0; DATA is i_wdata msb-first; oe=1 throughout.
- Read frame:
  - oe=0 from the first TA bit through the end of DATA.
  - TA bit-2 sample ≠ 0 sets the error, latched to o_ta_err at done.
  - The 16 DATA samples are shifted msb-first into an internal register.
- Completion:
  - Occurs at cycle T+1+2*CLK_DIV*(PREAMBLE_LEN+32), i.e. the end of the last high phase.
  - At completion: o_mdc=0, oe=0, o_mdio_out=1, o_done pulse, o_cmd_ready=1.
  - Reads additionally update o_rdata and o_ta_err and pulse o_rdata_valid.
  - Writes leave o_rdata and o_ta_err unchanged.
- Back-to-back: a command presented in the done cycle is accepted in that cycle; the next frame starts the following cycle.

Optional Feature:
- MDIO_PREAMBLE_SUPPRESS_EN defined:
  - Adds port i_preamble_suppress (in, 1), captured at accept.
  - When 1, the PREAMBLE state is skipped; latency becomes T+1+2*CLK_DIV*32.
- Undefined: the port is absent and PREAMBLE_LEN bits are always sent.

Decomposition:
- Package mdio_pkg holds:
  - Constants MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, MDIO_TA_WR=2'b10.
  - Field widths (PHYAD 5, REGAD 5, DATA 16, HDR 14).
  - State typedef.
- Sub-module mdio_clk_gen: divider producing o_mdc, a rise strobe and a fall strobe; enabled only while busy; sync clear.

Test Plan (CLK_DIV=2, PREAMBLE_LEN=32):
- Write phy=1 reg=0 data=0x1140 at T:
  - Serial stream = 32×'1', 01 01 00001 00000 10 0001000101000000.
  - oe=1 throughout; o_done at T+257; o_rdata_valid stays 0.
- Read phy=3 reg=2, PHY model drives TA '0' then 0x0141:
  - oe falls at the TA start; o_rdata=0x0141; o_rdata_valid and o_done pulse at T+257; o_ta_err=0.
- Read with no PHY (i_mdio_in held 1):
  - o_rdata=0xFFFF, o_ta_err=1.
- i_cmd_valid held high with two commands:
  - Second accepted in the first's done cycle; MDC gap = 0 cycles.
  - Pulses asserted during busy accept nothing.
- i_reset_n low for 1 cycle mid-DATA:
  - Next cycle o_mdc=0, oe=0, o_mdio_out=1, o_cmd_ready=1, no o_done.
  - A new command then completes normally.
- MDIO_PREAMBLE_SUPPRESS_EN with i_preamble_suppress=1:
  - Frame starts with 01 immediately; o_done at T+129.
